chunked_seq_adder: RTL and testbench
====================================

Name: chunked_seq_adder

Overview:
- Parametrised, multi-cycle successor to the team's flat 32-bit ripple adder.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, carrying between chunks in a register. This trades latency for a short critical path.
- Uses a start/busy/done handshake and reports carry-out and signed overflow.
- Sits in datapaths where a full-width single-cycle carry chain misses timing.

Parameters:
- WIDTH, 32, operand/result width in bits. Must be a multiple of CHUNK.
- CHUNK, 8, bits added per clock. Must be >= 1; CHUNK == WIDTH is legal (single pass).
- NCHUNK (localparam), WIDTH/CHUNK, number of chunk passes.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; captured on the accepted start edge.
- b  input  WIDTH  operand B; captured on the accepted start edge.
- cin  input  1  carry-in (borrow-in when sub=1); captured with a and b.
- sub  input  1  0 = add, 1 = subtract; captured with a and b.
- busy  output  1  high while chunks are being processed.
- done  output  1  one-cycle pulse marking a valid result.
- sum  output  WIDTH  result; held until the next completion.
- cout  output  1  carry out of MSB (for sub: 1 = no borrow).
- ovf  output  1  two's-complement overflow.

Behaviour:
- Reset:
  - Asynchronous, takes effect whenever rst_n=0, including mid-operation.
  - state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0.
  - Chunk counter, carry register and operand registers all cleared.
  - Operation restarts only on a new start after rst_n deasserts.
- States:
  - IDLE: start=1 at an edge -> RUN; otherwise stay.
  - RUN: after the last chunk -> DONE.
  - DONE: start=1 -> RUN (back-to-back); otherwise -> IDLE.
- Capture on the accepted start edge:
  - A_r=a; B_r = sub ? ~b : b; carry = cin ^ sub; counter=0.
  - Result: sub=0 gives a+b+cin; sub=1 gives a-b-cin.
- RUN, one chunk per edge, counter i = 0..NCHUNK-1:
  - {c, s} = A_r[i*CHUNK +: CHUNK] + B_r[i*CHUNK +: CHUNK] + carry.
  - s is written into the internal result register; carry=c.
  - On the last chunk, the carry into the MSB is recorded for overflow.
- Completion edge (the edge that processes chunk NCHUNK-1):
  - sum = full internal result; cout = final carry; ovf = carry_into_msb ^ cout.
  - busy=0, done=1 for exactly one cycle.
- Latency:
  - done rises NCHUNK edges after the start edge (WIDTH=32, CHUNK=8: 4 edges).
  - busy is high from the start edge until the completion edge.
- Output stability: sum, cout and ovf change only at completion edges (or reset). They never show partial results.
- start while busy=1 is ignored; no queueing. Inputs a, b, cin and sub may change freely after capture.
- start asserted in the DONE cycle is accepted: the new operation begins, done drops next cycle, busy rises.
- Widths: all arithmetic is modulo 2^WIDTH; carry beyond MSB goes only to cout.

Test Plan:
- Add, WIDTH=32/CHUNK=8: a=a4202b00, b=0f01da11, cin=1, sub=0, start pulse -> done exactly 4 edges later; sum=b3220512, cout=0, ovf=0; busy high for those 4 cycles.
- Wrap: a=ffffffff, b=00000001, cin=0 -> sum=00000000, cout=1, ovf=0. Carry must ripple through all 4 chunks.
- Signed overflow: a=7fffffff, b=00000001, cin=0 -> sum=80000000, cout=0, ovf=1.
- Subtract: a=00000005, b=00000007, sub=1, cin=0 -> sum=fffffffe, cout=0 (borrow), ovf=0.
  - Then a=00000007, b=00000005, sub=1, cin=1 -> sum=00000001, cout=1.
- Handshake edge cases:
  - start re-pulsed at cycle 2 of RUN -> ignored; result matches the first operands.
  - start held in the DONE cycle -> second result arrives 4 edges later with no IDLE gap.
- Reset mid-op: rst_n low during RUN chunk 2 -> busy, done, sum, cout and ovf go 0 immediately (asynchronous). After release with no start, all outputs stay 0.
- Parameter sweep (CHUNK=32, CHUNK=1 and WIDTH=16/CHUNK=4) with random vectors -> sum/cout/ovf match the reference model; done latency = WIDTH/CHUNK edges.

Source files
------------

// File: rtl/chunked_seq_adder_if.sv
// Handshake and operand/result bundle for chunked_seq_adder.
// master drives requests, slave returns status and results.
interface chunked_seq_adder_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/chunked_seq_adder.sv
// Multi-cycle add/subtract: CHUNK bits per clock with a registered inter-chunk carry.
// Results (sum/cout/ovf) update only on the completion edge, flagged by a one-cycle done.
module chunked_seq_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input logic                clk,
  input logic                rst_n,
  chunked_seq_adder_if.slave bus
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LastIdx = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic             msb_cin;
  logic             last;

  always_comb begin
    a_chunk   = a_q[cnt_q*CHUNK +: CHUNK];
    b_chunk   = b_q[cnt_q*CHUNK +: CHUNK];
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    // Carry into the chunk MSB recovered from its sum bit; on the last chunk it is the word MSB.
    msb_cin   = chunk_sum[CHUNK-1] ^ a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1];
    last      = (cnt_q == LastIdx);

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d = StRun;
          a_d     = bus.a;
          // Subtract as a + ~b + ~borrow_in.
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.cin ^ bus.sub;
          cnt_d   = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        res_d[cnt_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
        carry_d = chunk_sum[CHUNK];
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          state_d = StDone;
          sum_d   = res_d;
          cout_d  = chunk_sum[CHUNK];
          ovf_d   = msb_cin ^ chunk_sum[CHUNK];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.busy = (state_q == StRun);
  assign bus.done = (state_q == StDone);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_chunked_seq_adder.sv
// Bench for chunked_seq_adder: directed and random operations against an arithmetic model,
// plus a parameter sweep (CHUNK=32, CHUNK=1, WIDTH=16/CHUNK=4) run in parallel.
module tb_chunked_seq_adder;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  chunked_seq_adder_if #(.WIDTH(32)) m ();
  chunked_seq_adder_if #(.WIDTH(32)) bus_c32 ();
  chunked_seq_adder_if #(.WIDTH(32)) bus_c1 ();
  chunked_seq_adder_if #(.WIDTH(16)) bus16 ();

  chunked_seq_adder #(.WIDTH(32), .CHUNK(8))  u_main (.clk(clk), .rst_n(rst_n), .bus(m));
  chunked_seq_adder #(.WIDTH(32), .CHUNK(32)) u_c32  (.clk(clk), .rst_n(rst_n), .bus(bus_c32));
  chunked_seq_adder #(.WIDTH(32), .CHUNK(1))  u_c1   (.clk(clk), .rst_n(rst_n), .bus(bus_c1));
  chunked_seq_adder #(.WIDTH(16), .CHUNK(4))  u_w16  (.clk(clk), .rst_n(rst_n), .bus(bus16));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns {ovf, cout, sum} from plain integer arithmetic on w-bit operands.
  function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic sub);
    longint unsigned mod, ua, ub, ci, tot;
    longint          sa, sb, r, half;
    logic [31:0]     s;
    logic            co, ov;
    mod  = 64'd1 << w;
    ua   = {32'b0, a} & (mod - 64'd1);
    ub   = {32'b0, b} & (mod - 64'd1);
    ci   = {63'b0, cin};
    half = longint'(mod >> 1);
    sa   = (ua >= (mod >> 1)) ? longint'(ua) - longint'(mod) : longint'(ua);
    sb   = (ub >= (mod >> 1)) ? longint'(ub) - longint'(mod) : longint'(ub);
    if (!sub) begin
      tot = ua + ub + ci;
      co  = (tot >= mod);
      s   = 32'(tot % mod);
      r   = sa + sb + longint'(ci);
    end else begin
      co  = (ua >= ub + ci);
      s   = 32'((ua + mod - ub - ci) % mod);
      r   = sa - sb - longint'(ci);
    end
    ov = (r >= half) || (r < -half);
    return {ov, co, s};
  endfunction

  // One operation on the main DUT; optionally re-pulses start mid-run (must be ignored).
  task automatic op_main(input logic [31:0] a, input logic [31:0] b, input logic cin,
                         input logic sub, input bit repulse);
    logic [33:0] exp;
    logic [31:0] prev;
    int          lat;
    exp     = model(32, a, b, cin, sub);
    prev    = m.sum;
    m.a     = a;
    m.b     = b;
    m.cin   = cin;
    m.sub   = sub;
    m.start = 1'b1;
    @(posedge clk); #1;
    m.start = 1'b0;
    m.a     = $urandom;
    m.b     = $urandom;
    m.cin   = 1'($urandom);
    m.sub   = 1'($urandom);
    check("busy_after_start", 32'(m.busy), 32'd1);
    check("done_after_start", 32'(m.done), 32'd0);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      if (repulse) m.start = (k == 2);
      @(posedge clk); #1;
      if (m.done) begin
        lat = k;
        break;
      end
      check("busy_during_run", 32'(m.busy), 32'd1);
      check("sum_stable_during_run", m.sum, prev);
    end
    m.start = 1'b0;
    check("latency", 32'(lat), 32'd4);
    check("busy_at_done", 32'(m.busy), 32'd0);
    check("sum", m.sum, exp[31:0]);
    check("cout", 32'(m.cout), 32'(exp[32]));
    check("ovf", 32'(m.ovf), 32'(exp[33]));
  endtask

  task automatic gap_main();
    @(posedge clk); #1;
    check("done_one_cycle", 32'(m.done), 32'd0);
    check("idle_not_busy", 32'(m.busy), 32'd0);
  endtask

  // Same operation on the three sweep DUTs at once, each with its own latency.
  task automatic sweep_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                          input logic sub);
    logic [33:0] e32, e16, r32, r1, r16;
    int          l32, l1, l16;
    e32 = model(32, a, b, cin, sub);
    e16 = model(16, a, b, cin, sub);
    bus_c32.a = a; bus_c32.b = b; bus_c32.cin = cin; bus_c32.sub = sub; bus_c32.start = 1'b1;
    bus_c1.a  = a; bus_c1.b  = b; bus_c1.cin  = cin; bus_c1.sub  = sub; bus_c1.start  = 1'b1;
    bus16.a = a[15:0]; bus16.b = b[15:0]; bus16.cin = cin; bus16.sub = sub; bus16.start = 1'b1;
    @(posedge clk); #1;
    bus_c32.start = 1'b0;
    bus_c1.start  = 1'b0;
    bus16.start   = 1'b0;
    l32 = -1; l1 = -1; l16 = -1;
    r32 = '0; r1 = '0; r16 = '0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (l32 < 0 && bus_c32.done) begin
        l32 = k;
        r32 = {bus_c32.ovf, bus_c32.cout, bus_c32.sum};
      end
      if (l1 < 0 && bus_c1.done) begin
        l1 = k;
        r1 = {bus_c1.ovf, bus_c1.cout, bus_c1.sum};
      end
      if (l16 < 0 && bus16.done) begin
        l16 = k;
        r16 = {bus16.ovf, bus16.cout, 16'b0, bus16.sum};
      end
    end
    check("c32_latency", 32'(l32), 32'd1);
    check("c1_latency", 32'(l1), 32'd32);
    check("w16_latency", 32'(l16), 32'd4);
    check("c32_sum", r32[31:0], e32[31:0]);
    check("c32_flags", 32'(r32[33:32]), 32'(e32[33:32]));
    check("c1_sum", r1[31:0], e32[31:0]);
    check("c1_flags", 32'(r1[33:32]), 32'(e32[33:32]));
    check("w16_sum", r16[31:0], e16[31:0]);
    check("w16_flags", 32'(r16[33:32]), 32'(e16[33:32]));
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t dir[5];

  initial begin
    tests = 0;
    fails = 0;
    dir[0] = '{32'ha4202b00, 32'h0f01da11, 1'b1, 1'b0, 32'hb3220512, 1'b0, 1'b0};
    dir[1] = '{32'hffffffff, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
    dir[2] = '{32'h7fffffff, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    dir[3] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hfffffffe, 1'b0, 1'b0};
    dir[4] = '{32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000001, 1'b1, 1'b0};

    m.start = 1'b0; m.a = '0; m.b = '0; m.cin = 1'b0; m.sub = 1'b0;
    bus_c32.start = 1'b0; bus_c32.a = '0; bus_c32.b = '0; bus_c32.cin = 1'b0; bus_c32.sub = 1'b0;
    bus_c1.start = 1'b0; bus_c1.a = '0; bus_c1.b = '0; bus_c1.cin = 1'b0; bus_c1.sub = 1'b0;
    bus16.start = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.sub = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(m.busy), 32'd0);
    check("reset_done", 32'(m.done), 32'd0);
    check("reset_sum", m.sum, 32'd0);
    check("reset_cout", 32'(m.cout), 32'd0);
    check("reset_ovf", 32'(m.ovf), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors with hand-computed results.
    for (int i = 0; i < 5; i++) begin
      op_main(dir[i].a, dir[i].b, dir[i].cin, dir[i].sub, 1'b0);
      check("dir_sum", m.sum, dir[i].sum);
      check("dir_cout", 32'(m.cout), 32'(dir[i].cout));
      check("dir_ovf", 32'(m.ovf), 32'(dir[i].ovf));
      gap_main();
    end

    // start re-pulsed while busy must not disturb the running operation.
    op_main($urandom, $urandom, 1'($urandom), 1'($urandom), 1'b1);
    gap_main();

    // start in the DONE cycle: back-to-back with no idle gap.
    op_main($urandom, $urandom, 1'($urandom), 1'($urandom), 1'b0);
    op_main($urandom, $urandom, 1'($urandom), 1'($urandom), 1'b0);
    gap_main();

    for (int i = 0; i < 12; i++) begin
      op_main($urandom, $urandom, 1'($urandom), 1'($urandom), 1'b0);
      if (i % 3 != 2) gap_main();
    end
    gap_main();

    // Asynchronous reset in the middle of a run.
    op_main(32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0);
    gap_main();
    m.a = $urandom; m.b = $urandom; m.cin = 1'b0; m.sub = 1'b0; m.start = 1'b1;
    @(posedge clk); #1;
    m.start = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    check("busy_before_reset", 32'(m.busy), 32'd1);
    check("sum_before_reset", m.sum, 32'd2);
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(m.busy), 32'd0);
    check("async_rst_done", 32'(m.done), 32'd0);
    check("async_rst_sum", m.sum, 32'd0);
    check("async_rst_cout", 32'(m.cout), 32'd0);
    check("async_rst_ovf", 32'(m.ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("post_rst_busy", 32'(m.busy), 32'd0);
    check("post_rst_done", 32'(m.done), 32'd0);
    check("post_rst_sum", m.sum, 32'd0);
    check("post_rst_flags", {30'b0, m.cout, m.ovf}, 32'd0);

    op_main($urandom, $urandom, 1'($urandom), 1'($urandom), 1'b0);
    gap_main();

    // Parameter sweep.
    sweep_op(32'hffffffff, 32'h00000001, 1'b0, 1'b0);
    sweep_op(32'h7fff7fff, 32'h00010001, 1'b0, 1'b0);
    sweep_op(32'h80008000, 32'h00010001, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      sweep_op($urandom, $urandom, 1'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
